adder_arbiter: RTL and testbench
================================

# adder_arbiter

Round-robin arbiter and two-stage elastic pipeline that shares the single scale-and-round `adder` datapath among `NUM_REQ` neuron requesters. Each requester presents an 8-bit signed operand and a 16-bit signed operand under a valid/ready handshake. The arbiter grants one requester per cycle, registers its operands in front of the adder, and captures the adder's 9-bit `{carry,sum}` result with the requester ID into an output register under a second valid/ready handshake. It sits between the per-neuron accumulate logic and the shared adder instance.

## Interface
- `NUM_REQ`, default 4: number of requesters; legal range 2..16.
- `ID_W`, default `$clog2(NUM_REQ)`: width of requester ID.
- `clk` input 1: single clock; all registers update on its rising edge.
- `rst_n` input 1: reset. Asynchronous assertion, active-low.
- `req_valid` input `[NUM_REQ]`: requester i presents operands.
- `req_ready` output `[NUM_REQ]`: requester i's operands accepted this cycle.
- `req_in1` input `[NUM_REQ]x8`: signed 8-bit operand per requester.
- `req_in2` input `[NUM_REQ]x16`: signed 16-bit operand per requester.
- `res_valid` output 1: result register holds a result.
- `res_ready` input 1: consumer accepts the result.
- `res_id` output `ID_W`: requester that produced the result.
- `res_sum` output 8: adder `sum`, passed through unmodified.
- `res_carry` output 1: adder `carry`, passed through unmodified.

## Operation
- Adder function: full = sext17(in1) + sext17(in2); `{carry,sum}` = full[15:7] + full[6], computed modulo 2^9 (round half up, arithmetic shift by 7). The arbiter never alters this value.
- Round-robin pointer `ptr` holds the last granted ID. The search starts at `ptr`+1 mod `NUM_REQ` and grants the first requester with `req_valid`=1. The grant is combinational; `ptr` updates only on an accepted handshake.
- S1 (operand register): `s1_valid`, `s1_id`, `s1_in1`, `s1_in2`; it drives the adder directly.
- S2 (result register): `res_valid`, `res_id`, `res_sum`, `res_carry`.
- `s2_load` = `s1_valid` & (!`res_valid` | `res_ready`).
- `s1_load` = !`s1_valid` | `s2_load`.
- `req_ready[i]` = `grant[i]` & `s1_load`. At most one bit of `req_ready` is high.
- On `s2_load`, S2 captures the adder output and `s1_id`. If `res_valid` & `res_ready` & !`s2_load`, then `res_valid` goes to 0.
- On an accepted handshake, S1 loads the granted operands and `s1_valid` goes to 1. If `s2_load` occurs with no grant, `s1_valid` goes to 0.
- No requester starves: a requester holding `req_valid` is granted within `NUM_REQ` accepted handshakes.
- Results leave in acceptance order. Nothing is dropped or duplicated.

## Timing
- Reset values: `res_valid`=0, `res_id`=0, `res_sum`=0, `res_carry`=0, `s1_valid`=0, `ptr`=`NUM_REQ`-1 (so requester 0 has first priority).
- `req_ready` is combinational. During reset it may be high, but no state changes while `rst_n`=0.
- Latency: a handshake at edge k loads S1, and `res_valid`=1 after edge k+1 when S2 is free. Fill latency is 2 edges; throughput is 1 result per cycle with `res_ready`=1.
- When `res_valid`=1 and `res_ready`=0, `res_*` stays stable. S1 can still fill once; after that all `req_ready`=0.
- Simultaneous consume and refill of S2 in the same cycle is legal and keeps `res_valid`=1.
- Reset asserted mid-operation clears both stages immediately; in-flight results are discarded. After release, the first grant goes to requester 0.
- A requester that deasserts `req_valid` before it is granted loses nothing. The grant moves on the same cycle.

## Structure
- Package `neuron_pkg` holds: the constants `IN1_W`=8, `IN2_W`=16, `RES_W`=9, `FRAC_SHIFT`=7; a typedef `adder_req_t` with fields in1 and in2; and a typedef `adder_res_t` with fields id, carry and sum.
- One sub-module, `rr_arbiter` (`NUM_REQ`): combinational grant from `req_valid` and `ptr`, plus the registered `ptr` update on accept.
- The existing `adder` is instantiated once, driven by S1.

## Test plan
- Reset: hold `rst_n`=0 with all `req_valid`=1 → `res_valid`=0 and outputs 0. The first accepted handshake after release is requester 0.
- Single request: requester 2 presents `in1`=0, `in2`=192, with `res_ready`=1 → 2 edges later `res_valid`=1, `res_id`=2, `res_sum`=2, `res_carry`=0.
- Negative rounding: `in1`=-128, `in2`=-64 → `res_sum`=8'hFF, `res_carry`=1 (-1.5 rounds to -1). Also `in1`=5, `in2`=10 → `res_sum`=0, `res_carry`=0.
- Fairness: all 4 requesters valid continuously, with distinct operands, `res_ready`=1 → `res_id` sequence 0,1,2,3,0,1,… with one result per cycle and every sum matching the adder function.
- Backpressure: streaming from requesters 1 and 3, then `res_ready`=0 for 3 cycles → `res_*` stable, one operand held in S1, all `req_ready`=0. On release, the results drain in order with no loss.
- Reset mid-stream: both stages full, `rst_n` pulsed low for 1 cycle → `res_valid` drops immediately with no clock edge needed. After release, grant order restarts at requester 0.

Source files
------------

// File: rtl/neuron_pkg.sv
// Shared widths and record types for the neuron-to-adder datapath.
// Also holds the fixed-point round-and-shift used by the shared adder.
package neuron_pkg;

   localparam int IN1_W      = 8;
   localparam int IN2_W      = 16;
   localparam int RES_W      = 9;
   localparam int FRAC_SHIFT = 7;
   localparam int MAX_ID_W   = 4;

   typedef struct packed {
      logic signed [IN1_W-1:0] in1;
      logic signed [IN2_W-1:0] in2;
   } adder_req_t;

   typedef struct packed {
      logic [MAX_ID_W-1:0] id;
      logic                carry;
      logic [IN1_W-1:0]    sum;
   } adder_res_t;

   // Arithmetic shift right by FRAC_SHIFT, rounding half up, modulo 2^RES_W.
   function automatic logic [RES_W-1:0] round_shift(input logic [IN2_W:0] full);
      return full[IN2_W-1:FRAC_SHIFT] + RES_W'(full[FRAC_SHIFT-1]);
   endfunction

endpackage

// File: rtl/adder.sv
// Shared scale-and-round adder: {carry,sum} = round(sext(in1) + sext(in2)) >> 7.
// Purely combinational; the caller registers its operands.
module adder
   import neuron_pkg::*;
(
   input  logic [IN1_W-1:0] in1,
   input  logic [IN2_W-1:0] in2,
   output logic [IN1_W-1:0] sum,
   output logic             carry
);

   logic [IN2_W:0] full;

   always_comb begin
      full = {{(IN2_W + 1 - IN1_W){in1[IN1_W-1]}}, in1} + {in2[IN2_W-1], in2};
   end

   assign {carry, sum} = round_shift(full);

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin grant among NUM_REQ requesters; search starts one past the last grant.
// The pointer only advances when the grant is actually accepted downstream.
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_REQ-1:0] req_valid,
   input  logic               accept,
   output logic [NUM_REQ-1:0] grant,
   output logic [ID_W-1:0]    grant_id,
   output logic               grant_any
);

   logic [ID_W-1:0] ptr_q;
   logic [ID_W-1:0] ptr_d;

   always_comb begin
      int idx;
      grant     = '0;
      grant_id  = '0;
      grant_any = 1'b0;
      idx       = 0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = (int'(ptr_q) + k) % NUM_REQ;
         if (!grant_any && req_valid[idx]) begin
            grant[idx] = 1'b1;
            grant_id   = ID_W'(idx);
            grant_any  = 1'b1;
         end
      end
   end

   always_comb begin
      ptr_d = accept ? grant_id : ptr_q;
   end

   // Reset to the last ID so requester 0 is searched first.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= ID_W'(NUM_REQ - 1);
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/adder_arbiter.sv
// Shares one adder among NUM_REQ requesters: round-robin grant, operand stage S1,
// result stage S2, each behind its own valid/ready handshake.
module adder_arbiter
   import neuron_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_REQ-1:0]            req_valid,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic [NUM_REQ-1:0][IN1_W-1:0] req_in1,
   input  logic [NUM_REQ-1:0][IN2_W-1:0] req_in2,
   output logic                          res_valid,
   input  logic                          res_ready,
   output logic [ID_W-1:0]               res_id,
   output logic [IN1_W-1:0]              res_sum,
   output logic                          res_carry
);

   logic [NUM_REQ-1:0] grant;
   logic [ID_W-1:0]    grant_id;
   logic               grant_any;
   logic               s1_load;
   logic               s2_load;
   logic               accept;
   adder_req_t         granted_op;

   logic               s1_valid_q, s1_valid_d;
   logic [ID_W-1:0]    s1_id_q, s1_id_d;
   adder_req_t         s1_op_q, s1_op_d;

   logic               res_valid_q, res_valid_d;
   logic [ID_W-1:0]    res_id_q, res_id_d;
   logic [IN1_W-1:0]   res_sum_q, res_sum_d;
   logic               res_carry_q, res_carry_d;

   logic [IN1_W-1:0]   add_sum;
   logic               add_carry;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_rr_arbiter (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .accept    (accept),
      .grant     (grant),
      .grant_id  (grant_id),
      .grant_any (grant_any)
   );

   adder u_adder (
      .in1   (s1_op_q.in1),
      .in2   (s1_op_q.in2),
      .sum   (add_sum),
      .carry (add_carry)
   );

   // S2 frees when empty or being consumed; S1 frees when empty or moving into S2.
   always_comb begin
      s2_load = s1_valid_q & (~res_valid_q | res_ready);
      s1_load = ~s1_valid_q | s2_load;
      accept  = grant_any & s1_load;
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_ready
         assign req_ready[gi] = grant[gi] & s1_load;
      end
   endgenerate

   always_comb begin
      granted_op.in1 = req_in1[grant_id];
      granted_op.in2 = req_in2[grant_id];
   end

   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_id_d    = s1_id_q;
      s1_op_d    = s1_op_q;
      if (accept) begin
         s1_valid_d = 1'b1;
         s1_id_d    = grant_id;
         s1_op_d    = granted_op;
      end else if (s2_load) begin
         s1_valid_d = 1'b0;
      end
   end

   always_comb begin
      res_valid_d = res_valid_q;
      res_id_d    = res_id_q;
      res_sum_d   = res_sum_q;
      res_carry_d = res_carry_q;
      if (s2_load) begin
         res_valid_d = 1'b1;
         res_id_d    = s1_id_q;
         res_sum_d   = add_sum;
         res_carry_d = add_carry;
      end else if (res_ready) begin
         res_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q  <= 1'b0;
         s1_id_q     <= '0;
         s1_op_q     <= '0;
         res_valid_q <= 1'b0;
         res_id_q    <= '0;
         res_sum_q   <= '0;
         res_carry_q <= 1'b0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_id_q     <= s1_id_d;
         s1_op_q     <= s1_op_d;
         res_valid_q <= res_valid_d;
         res_id_q    <= res_id_d;
         res_sum_q   <= res_sum_d;
         res_carry_q <= res_carry_d;
      end
   end

   assign res_valid = res_valid_q;
   assign res_id    = res_id_q;
   assign res_sum   = res_sum_q;
   assign res_carry = res_carry_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter: vector table of single requests plus
// hand-written sequences for fairness, backpressure and mid-stream reset.
module tb_adder_arbiter;

   localparam int N = 4;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [N-1:0]     req_valid;
   logic [N-1:0]     req_ready;
   logic [N-1:0][7:0]  req_in1;
   logic [N-1:0][15:0] req_in2;
   logic             res_valid;
   logic             res_ready;
   logic [1:0]       res_id;
   logic [7:0]       res_sum;
   logic             res_carry;

   int total = 0;
   int bad   = 0;

   typedef struct {
      int         idx;
      logic [7:0] in1;
      logic [15:0] in2;
      logic [7:0] sum;
      logic       carry;
   } vec_t;

   vec_t vecs[8];

   adder_arbiter #(.NUM_REQ(N)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_in1   (req_in1),
      .req_in2   (req_in2),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_id    (res_id),
      .res_sum   (res_sum),
      .res_carry (res_carry)
   );

   always #5 clk = ~clk;

   function automatic logic [8:0] model(input logic [7:0] a, input logic [15:0] b);
      logic signed [16:0] f;
      f = $signed(a) + $signed(b);
      return 9'((f >>> 7) + 17'(f[6]));
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", name, act, exp);
      end
   endtask

   task automatic chk_res(input string name, input int id, input logic [7:0] a, input logic [15:0] b);
      logic [8:0] r;
      r = model(a, b);
      chk({name, "_valid"}, 32'(res_valid), 32'd1);
      chk({name, "_id"}, 32'(res_id), 32'(id));
      chk({name, "_res"}, {23'd0, res_carry, res_sum}, {23'd0, r});
      $display("txn %s id=%0d carry=%0d sum=%0h", name, res_id, res_carry, res_sum);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   initial begin
      logic [7:0]  hold_sum;
      logic [1:0]  hold_id;
      logic        hold_carry;

      vecs[0] = '{2, 8'h00, 16'h00C0, 8'h02, 1'b0};
      vecs[1] = '{1, 8'h80, 16'hFFC0, 8'hFF, 1'b1};
      vecs[2] = '{3, 8'h05, 16'h000A, 8'h00, 1'b0};
      vecs[3] = '{0, 8'h7F, 16'h7FFF, 8'h01, 1'b1};
      vecs[4] = '{0, 8'hFF, 16'hFFFF, 8'h00, 1'b0};
      vecs[5] = '{1, 8'h80, 16'h8000, 8'hFF, 1'b0};
      vecs[6] = '{2, 8'h40, 16'h0000, 8'h01, 1'b0};
      vecs[7] = '{3, 8'h00, 16'hFFBF, 8'hFF, 1'b1};

      // Reset held with every requester valid; operands distinct per requester.
      rst_n     = 1'b0;
      res_ready = 1'b1;
      req_valid = '1;
      for (int i = 0; i < N; i++) begin
         req_in1[i] = 8'(i * 3 + 1);
         req_in2[i] = 16'(i * 200 - 300);
      end
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", 32'(res_valid), 32'd0);
      chk("rst_id", 32'(res_id), 32'd0);
      chk("rst_sum", 32'(res_sum), 32'd0);
      chk("rst_carry", 32'(res_carry), 32'd0);
      rst_n = 1'b1;
      #1;
      chk("first_ready", 32'(req_ready), 32'b0001);

      // Fairness: after edge n the result is from requester (n-2) mod 4.
      for (int n = 1; n <= 10; n++) begin
         step();
         chk("fair_ready", 32'(req_ready), 32'(1 << (n % N)));
         if (n >= 2) begin
            chk_res("fair", (n - 2) % N, req_in1[(n - 2) % N], req_in2[(n - 2) % N]);
         end else begin
            chk("fair_fill", 32'(res_valid), 32'd0);
         end
      end

      // Table of single requests through an otherwise idle pipeline.
      req_valid = '0;
      do_reset();
      for (int v = 0; v < 8; v++) begin
         req_in1[vecs[v].idx]   = vecs[v].in1;
         req_in2[vecs[v].idx]   = vecs[v].in2;
         req_valid[vecs[v].idx] = 1'b1;
         #1;
         chk("vec_ready", 32'(req_ready), 32'(1 << vecs[v].idx));
         step();
         req_valid = '0;
         chk("vec_lat", 32'(res_valid), 32'd0);
         step();
         chk("vec_valid", 32'(res_valid), 32'd1);
         chk("vec_id", 32'(res_id), 32'(vecs[v].idx));
         chk("vec_res", {23'd0, res_carry, res_sum}, {23'd0, vecs[v].carry, vecs[v].sum});
         $display("txn vec%0d id=%0d carry=%0d sum=%0h", v, res_id, res_carry, res_sum);
         step();
         chk("vec_drain", 32'(res_valid), 32'd0);
      end

      // Backpressure with requesters 1 and 3 streaming.
      do_reset();
      req_in1[1] = 8'h11; req_in2[1] = 16'h0456;
      req_in1[3] = 8'hF0; req_in2[3] = 16'hFC00;
      req_valid  = 4'b1010;
      step();
      chk("bp_ready1", 32'(req_ready), 32'b1000);
      step();
      chk_res("bp_first", 1, 8'h11, 16'h0456);
      res_ready = 1'b0;
      #1;
      chk("bp_stall_ready", 32'(req_ready), 32'd0);
      hold_sum   = res_sum;
      hold_id    = res_id;
      hold_carry = res_carry;
      for (int c = 0; c < 3; c++) begin
         step();
         chk("bp_hold_valid", 32'(res_valid), 32'd1);
         chk("bp_hold_res", {22'd0, hold_id, hold_carry, hold_sum}, {22'd0, res_id, res_carry, res_sum});
         chk("bp_hold_ready", 32'(req_ready), 32'd0);
      end
      res_ready = 1'b1;
      #1;
      chk("bp_release_ready", 32'(req_ready), 32'b0010);
      step();
      chk_res("bp_d1", 3, 8'hF0, 16'hFC00);
      req_valid = '0;
      step();
      chk_res("bp_d2", 1, 8'h11, 16'h0456);
      step();
      chk("bp_empty", 32'(res_valid), 32'd0);

      // Reset pulsed with both stages full.
      do_reset();
      req_valid = '1;
      res_ready = 1'b0;
      step();
      step();
      chk("mid_full", 32'(res_valid), 32'd1);
      chk("mid_full_ready", 32'(req_ready), 32'd0);
      #1 rst_n = 1'b0;
      #1;
      chk("mid_async_valid", 32'(res_valid), 32'd0);
      chk("mid_async_out", {23'd0, res_carry, res_sum}, 32'd0);
      step();
      rst_n     = 1'b1;
      res_ready = 1'b1;
      #1;
      chk("mid_restart_ready", 32'(req_ready), 32'b0001);
      step();
      step();
      chk_res("mid_r0", 0, req_in1[0], req_in2[0]);
      step();
      chk_res("mid_r1", 1, req_in1[1], req_in2[1]);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
